// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder with per-format immediate checks, address tagging
// and a small output FIFO between the program generator and instruction memory.
module instr_encoder #(
  parameter int          DEPTH     = 2,
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [1:0]        err_code
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_t;

  fmt_t        fmt;
  logic [31:0] word;
  logic        range_ok;
  logic        misaligned;
  logic        has_err;
  logic [1:0]  code;

  always_comb begin
    fmt = FMT_NONE;
    case (in_opcode)
      5'b01100:                                        fmt = FMT_R;
      5'b00000, 5'b00011, 5'b00100, 5'b11001, 5'b11100: fmt = FMT_I;
      5'b01000:                                        fmt = FMT_S;
      5'b11000:                                        fmt = FMT_B;
      5'b00101, 5'b01101:                              fmt = FMT_U;
      5'b11011:                                        fmt = FMT_J;
      default:                                         fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    word       = '0;
    word[6:0]  = {in_opcode, 2'b11};
    range_ok   = 1'b1;
    misaligned = 1'b0;
    case (fmt)
      FMT_R: word[31:7] = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd};
      FMT_I: begin
        word[31:7] = {in_imm[11:0], in_rs1, in_funct3, in_rd};
        range_ok   = (&in_imm[31:11]) | ~(|in_imm[31:11]);
      end
      FMT_S: begin
        word[31:7] = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0]};
        range_ok   = (&in_imm[31:11]) | ~(|in_imm[31:11]);
      end
      FMT_B: begin
        word[31:7] = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11]};
        range_ok   = (&in_imm[31:12]) | ~(|in_imm[31:12]);
        misaligned = in_imm[0];
      end
      FMT_U: begin
        word[31:7] = {in_imm[31:12], in_rd};
        range_ok   = ~(|in_imm[11:0]);
      end
      FMT_J: begin
        word[31:7] = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd};
        range_ok   = (&in_imm[31:20]) | ~(|in_imm[31:20]);
        misaligned = in_imm[0];
      end
      default: ;
    endcase
  end

  // Unsupported outranks misalignment, which outranks range.
  always_comb begin
    code = 2'd0;
    if (fmt == FMT_NONE) code = 2'd1;
    else if (misaligned) code = 2'd3;
    else if (!range_ok)  code = 2'd2;
  end
  assign has_err = (code != 2'd0);

  logic [31:0]       mem_instr [DEPTH];
  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] addr_cnt;
  logic              accept, push, pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && !has_err;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
  assign out_addr  = out_valid ? mem_addr[rd_ptr]  : '0;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= word;
      mem_addr[wr_ptr]  <= addr_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      addr_cnt  <= ADDR_W'(BASE_ADDR);
      err_valid <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr   <= ptr_inc(wr_ptr);
        addr_cnt <= addr_cnt + ADDR_W'(1);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      err_valid <= accept && has_err;
      if (accept && has_err) err_code <= code;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed plan cases plus randomized traffic
// compared every cycle against an arithmetic reference model with a queue-based FIFO.
module tb_instr_encoder;
  localparam int DEPTH  = 2;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_opcode, in_rd, in_rs1, in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err_valid;
  logic [1:0]        err_code;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] q_instr[$];
  int          q_addr[$];
  int          m_addr;
  int          m_code;
  bit          m_pulse;

  logic [4:0] ops [11] = '{5'b01100, 5'b00000, 5'b00011, 5'b00100, 5'b11001, 5'b11100,
                           5'b01000, 5'b11000, 5'b00101, 5'b01101, 5'b11011};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference: words assembled by placing extracted immediate slices at their bit offsets;
  // legality judged on the signed value of the immediate.
  task automatic model_encode(input logic [4:0] op, input logic [4:0] rd5, input logic [4:0] rs15,
                              input logic [4:0] rs25, input logic [2:0] f3i, input logic [6:0] f7i,
                              input logic [31:0] imm, output int code, output logic [31:0] w);
    logic [31:0] rd, rs1, rs2, f3, f7;
    int s;
    bit in_rng;
    bit odd;
    rd = 32'(rd5); rs1 = 32'(rs15); rs2 = 32'(rs25); f3 = 32'(f3i); f7 = 32'(f7i);
    s = $signed(imm);
    odd = imm[0];
    w = (32'(op) << 2) | 32'd3;
    code = 0;
    in_rng = 1'b1;
    case (op)
      5'b01100: w = w | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
      5'b00000, 5'b00011, 5'b00100, 5'b11001, 5'b11100: begin
        w = w | (rd << 7) | (f3 << 12) | (rs1 << 15) | (fld(imm, 11, 0) << 20);
        in_rng = (s >= -2048) && (s <= 2047);
      end
      5'b01000: begin
        w = w | (fld(imm, 4, 0) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
              | (fld(imm, 11, 5) << 25);
        in_rng = (s >= -2048) && (s <= 2047);
      end
      5'b11000: begin
        w = w | (fld(imm, 11, 11) << 7) | (fld(imm, 4, 1) << 8) | (f3 << 12) | (rs1 << 15)
              | (rs2 << 20) | (fld(imm, 10, 5) << 25) | (fld(imm, 12, 12) << 31);
        in_rng = (s >= -4096) && (s <= 4095);
        if (odd) code = 3;
      end
      5'b00101, 5'b01101: begin
        w = w | (rd << 7) | (imm & 32'hFFFF_F000);
        in_rng = (imm % 32'd4096) == 32'd0;
      end
      5'b11011: begin
        w = w | (rd << 7) | (fld(imm, 19, 12) << 12) | (fld(imm, 11, 11) << 20)
              | (fld(imm, 10, 1) << 21) | (fld(imm, 20, 20) << 31);
        in_rng = (s >= -(1 << 20)) && (s <= (1 << 20) - 1);
        if (odd) code = 3;
      end
      default: code = 1;
    endcase
    if (code == 0 && !in_rng) code = 2;
  endtask

  task automatic compare_all();
    chk("in_ready", 32'(in_ready), 32'(q_instr.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q_instr.size() > 0));
    if (q_instr.size() > 0) begin
      chk("out_instr", out_instr, q_instr[0]);
      chk("out_addr", 32'(out_addr), 32'(q_addr[0]));
    end
    chk("err_valid", 32'(err_valid), 32'(m_pulse));
    chk("err_code", 32'(err_code), 32'(m_code));
  endtask

  task automatic model_update();
    bit acc, pop;
    int code;
    logic [31:0] w;
    acc = in_valid && (q_instr.size() < DEPTH);
    pop = (q_instr.size() > 0) && out_ready;
    m_pulse = 1'b0;
    if (pop) begin
      void'(q_instr.pop_front());
      void'(q_addr.pop_front());
    end
    if (acc) begin
      model_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, code, w);
      if (code == 0) begin
        q_instr.push_back(w);
        q_addr.push_back(m_addr);
        m_addr = (m_addr + 1) % (1 << ADDR_W);
      end else begin
        m_pulse = 1'b1;
        m_code = code;
      end
    end
  endtask

  task automatic cycle();
    compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_fields(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm);
    set_fields(op, rd, rs1, rs2, f3, f7, imm);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_err_valid"}, 32'(err_valid), 32'd0);
    chk({tag, "_err_code"}, 32'(err_code), 32'd0);
    chk({tag, "_out_instr"}, out_instr, 32'd0);
    q_instr.delete();
    q_addr.delete();
    m_addr = 0; m_code = 0; m_pulse = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_fields();
    logic [31:0] base;
    logic signed [31:0] t;
    int w;
    base = $urandom;
    case ($urandom_range(0, 3))
      0: w = 12;
      1: w = 13;
      2: w = 21;
      default: w = 32;
    endcase
    t = base << (32 - w);
    in_imm = t >>> (32 - w);
    if ($urandom_range(0, 3) == 0) in_imm[11:0] = 12'd0;
    if ($urandom_range(0, 1) == 1) in_imm[0] = 1'b0;
    in_opcode = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                            : ops[$urandom_range(0, 10)];
    in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
    in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_fields(5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    m_addr = 0; m_code = 0; m_pulse = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_err_valid", 32'(err_valid), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed plan words
    send(5'b01100, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0);
    chk("r_valid", 32'(out_valid), 32'd1);
    chk("r_word", out_instr, 32'h403100B3);
    chk("r_addr", 32'(out_addr), 32'd0);
    cycle();
    send(5'b00100, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    chk("i_word", out_instr, 32'hFFF00293);
    chk("i_addr", 32'(out_addr), 32'd1);
    cycle();
    send(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
    chk("b_word", out_instr, 32'h00208463);
    chk("b_addr", 32'(out_addr), 32'd2);
    cycle();

    // Error causes
    send(5'b11111, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    chk("unsup_pulse", 32'(err_valid), 32'd1);
    chk("unsup_code", 32'(err_code), 32'd1);
    chk("unsup_noword", 32'(out_valid), 32'd0);
    cycle();
    send(5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    chk("misal_code", 32'(err_code), 32'd3);
    cycle();
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    chk("range_code", 32'(err_code), 32'd2);
    cycle();
    chk("err_held", 32'(err_code), 32'd2);
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
    chk("post_err_addr", 32'(out_addr), 32'd3);
    cycle();

    // Backpressure: third word waits until a slot frees
    out_ready = 1'b0;
    set_fields(5'b00100, 5'd7, 5'd3, 5'd0, 3'd1, 7'd0, 32'd9);
    in_valid = 1'b1;
    repeat (3) cycle();
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    repeat (2) cycle();
    in_valid = 1'b0;
    repeat (3) cycle();

    // Reset with two words queued, then with an error pulse pending
    out_ready = 1'b0;
    send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    send(5'b00100, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    do_reset("rst_q");
    send(5'b00100, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    chk("post_rst_addr", 32'(out_addr), 32'd0);
    send(5'b11111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    chk("pre_rst_pulse", 32'(err_valid), 32'd1);
    do_reset("rst_e");

    // Wrap of the 2-bit address tag
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(5'b01100, 5'(k), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
      chk("wrap_addr", 32'(out_addr), 32'(k % 4));
      cycle();
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rand_fields();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
